// File: rtl/cycle_sequencer.sv
// cycle_sequencer: four-phase instruction cycle controller (FETCH, DECODE,
// EXECUTE, STORE) with an instruction register, a retired-instruction
// counter and a memory-wait watchdog that latches a sticky fault.
//
// Ports:
//   clock              system clock, rising-edge active
//   reset              synchronous active-high reset
//   run                allows leaving FETCH
//   instruction_in     16-bit ROM instruction word
//   instruction_valid  instruction_in is valid
//   instruction_enable fetch request
//   read_enable        RAM load pending (sampled in EXECUTE)
//   write_enable       RAM store pending (sampled in EXECUTE)
//   mem_ready          RAM load data valid / store accepted
//   state              current cycle state
//   opcode, x, y, z    instruction register nibbles [15:12] .. [3:0]
//   retired            completed-instruction count (wraps at 2^16)
//   fault              sticky memory-timeout flag
//   halted             registered: FETCH and (run low or fault set)

module cycle_sequencer #(
    parameter logic [7:0] WAIT_LIMIT = 8'd16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instruction_in,
    input  logic        instruction_valid,
    input  logic        instruction_enable,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic        mem_ready,
    output logic [1:0]  state,
    output logic [3:0]  opcode,
    output logic [3:0]  x,
    output logic [3:0]  y,
    output logic [3:0]  z,
    output logic [15:0] retired,
    output logic        fault,
    output logic        halted
);

    // state   | meaning
    // FETCH   | wait for run + valid fetch request, capture instruction
    // DECODE  | one-cycle decode slot
    // EXECUTE | execute; holds while a memory access waits for mem_ready
    // STORE   | write-back; retires the instruction

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        DECODE  = 2'b01,
        EXECUTE = 2'b10,
        STORE   = 2'b11
    } cycle_state_t;

    cycle_state_t cur_state;
    logic [15:0]  instr_reg;
    logic [7:0]   wait_cnt;
    logic         access_pending;

    assign access_pending = read_enable | write_enable;

    assign state  = cur_state;
    assign opcode = instr_reg[15:12];
    assign x      = instr_reg[11:8];
    assign y      = instr_reg[7:4];
    assign z      = instr_reg[3:0];

    // halted is computed from the next state so it stays a pure register
    // output rather than a decode of the live run input.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= FETCH;
            instr_reg <= 16'h0000;
            retired   <= 16'h0000;
            fault     <= 1'b0;
            wait_cnt  <= 8'd0;
            halted    <= ~run;
        end else begin
            case (cur_state)
                FETCH: begin
                    if (run && instruction_enable && instruction_valid && !fault) begin
                        cur_state <= DECODE;
                        instr_reg <= instruction_in;
                        halted    <= 1'b0;
                    end else begin
                        halted    <= ~run | fault;
                    end
                end
                DECODE: begin
                    cur_state <= EXECUTE;
                    wait_cnt  <= 8'd0;
                    halted    <= 1'b0;
                end
                EXECUTE: begin
                    halted <= 1'b0;
                    if (!access_pending || mem_ready) begin
                        // mem_ready beats the watchdog on the limit cycle
                        cur_state <= STORE;
                    end else if (WAIT_LIMIT != 8'd0 && wait_cnt == WAIT_LIMIT) begin
                        cur_state <= FETCH;
                        fault     <= 1'b1;
                        halted    <= 1'b1;
                    end else if (wait_cnt != 8'hFF) begin
                        // saturate so a disabled watchdog never wraps
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                STORE: begin
                    cur_state <= FETCH;
                    retired   <= retired + 16'd1;
                    halted    <= ~run | fault;
                end
                default: begin
                    cur_state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Testbench for cycle_sequencer: table of single-cycle vectors plus
// hand-written sequences for watchdog timeout, limit-cycle race and
// retired-counter wrap.

module tb_cycle_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] instruction_in;
    logic        instruction_valid;
    logic        instruction_enable;
    logic        read_enable;
    logic        write_enable;
    logic        mem_ready;
    logic [1:0]  state;
    logic [3:0]  opcode;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [3:0]  z;
    logic [15:0] retired;
    logic        fault;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    cycle_sequencer #(.WAIT_LIMIT(8'd4)) dut (
        .clock              (clock),
        .reset              (reset),
        .run                (run),
        .instruction_in     (instruction_in),
        .instruction_valid  (instruction_valid),
        .instruction_enable (instruction_enable),
        .read_enable        (read_enable),
        .write_enable       (write_enable),
        .mem_ready          (mem_ready),
        .state              (state),
        .opcode             (opcode),
        .x                  (x),
        .y                  (y),
        .z                  (z),
        .retired            (retired),
        .fault              (fault),
        .halted             (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        run;
        logic        ie;
        logic        iv;
        logic [15:0] instr;
        logic        re;
        logic        we;
        logic        mr;
        logic [1:0]  st;
        logic [15:0] ir;
        logic [15:0] ret;
        logic        flt;
        logic        hlt;
    } vec_t;

    vec_t vecs[24];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_i, input logic run_i, input logic ie_i,
                         input logic iv_i, input logic [15:0] instr_i,
                         input logic re_i, input logic we_i, input logic mr_i);
        reset              = rst_i;
        run                = run_i;
        instruction_enable = ie_i;
        instruction_valid  = iv_i;
        instruction_in     = instr_i;
        read_enable        = re_i;
        write_enable       = we_i;
        mem_ready          = mr_i;
    endtask

    initial begin
        // rst run ie iv instr     re we mr | st  ir        ret  flt hlt
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0, 2'd0,16'h0000,16'd0,1'b0,1'b1};
        vecs[1]  = '{1'b0,1'b0,1'b1,1'b1,16'h0123,1'b0,1'b0,1'b0, 2'd0,16'h0000,16'd0,1'b0,1'b1};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,16'h0123,1'b0,1'b0,1'b0, 2'd0,16'h0000,16'd0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,16'h0123,1'b0,1'b0,1'b0, 2'd0,16'h0000,16'd0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b1,1'b1,16'h0123,1'b0,1'b0,1'b0, 2'd1,16'h0123,16'd0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,16'hFFFF,1'b0,1'b0,1'b0, 2'd2,16'h0123,16'd0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,16'hFFFF,1'b0,1'b0,1'b0, 2'd3,16'h0123,16'd0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,16'hFFFF,1'b0,1'b0,1'b0, 2'd0,16'h0123,16'd1,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,16'hFFFF,1'b0,1'b0,1'b0, 2'd0,16'h0123,16'd1,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b1,1'b1,16'hC456,1'b0,1'b0,1'b0, 2'd1,16'hC456,16'd1,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b1,1'b0,1'b0,16'hC456,1'b1,1'b0,1'b1, 2'd2,16'hC456,16'd1,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0,16'hC456,1'b1,1'b0,1'b0, 2'd2,16'hC456,16'd1,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b1,1'b0,1'b0,16'hC456,1'b1,1'b0,1'b0, 2'd2,16'hC456,16'd1,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b1,1'b0,1'b0,16'hC456,1'b1,1'b0,1'b1, 2'd3,16'hC456,16'd1,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b1,1'b0,1'b0,16'hC456,1'b0,1'b0,1'b0, 2'd0,16'hC456,16'd2,1'b0,1'b0};
        vecs[15] = '{1'b0,1'b1,1'b1,1'b1,16'h0789,1'b0,1'b0,1'b0, 2'd1,16'h0789,16'd2,1'b0,1'b0};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b0,16'h0789,1'b0,1'b0,1'b0, 2'd2,16'h0789,16'd2,1'b0,1'b0};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b0,16'h0789,1'b0,1'b0,1'b0, 2'd3,16'h0789,16'd2,1'b0,1'b0};
        vecs[18] = '{1'b0,1'b0,1'b0,1'b0,16'h0789,1'b0,1'b0,1'b0, 2'd0,16'h0789,16'd3,1'b0,1'b1};
        vecs[19] = '{1'b0,1'b0,1'b1,1'b1,16'h0AAA,1'b0,1'b0,1'b0, 2'd0,16'h0789,16'd3,1'b0,1'b1};
        vecs[20] = '{1'b0,1'b1,1'b1,1'b1,16'h0ABC,1'b0,1'b0,1'b0, 2'd1,16'h0ABC,16'd3,1'b0,1'b0};
        vecs[21] = '{1'b0,1'b1,1'b0,1'b0,16'h0ABC,1'b1,1'b0,1'b0, 2'd2,16'h0ABC,16'd3,1'b0,1'b0};
        vecs[22] = '{1'b0,1'b1,1'b0,1'b0,16'h0ABC,1'b1,1'b0,1'b0, 2'd2,16'h0ABC,16'd3,1'b0,1'b0};
        vecs[23] = '{1'b1,1'b1,1'b0,1'b0,16'h0ABC,1'b1,1'b0,1'b0, 2'd0,16'h0000,16'd0,1'b0,1'b0};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].run, vecs[i].ie, vecs[i].iv, vecs[i].instr,
                  vecs[i].re, vecs[i].we, vecs[i].mr);
            step();
            chk($sformatf("v%0d state", i),   {14'd0, state}, {14'd0, vecs[i].st});
            chk($sformatf("v%0d ir", i),      {opcode, x, y, z}, vecs[i].ir);
            chk($sformatf("v%0d retired", i), retired, vecs[i].ret);
            chk($sformatf("v%0d fault", i),   {15'd0, fault}, {15'd0, vecs[i].flt});
            chk($sformatf("v%0d halted", i),  {15'd0, halted}, {15'd0, vecs[i].hlt});
        end

        // Watchdog timeout: store with mem_ready held low, limit 4.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'hD321, 1'b0, 1'b0, 1'b0);
        step();
        chk("to decode", {14'd0, state}, 16'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hD321, 1'b0, 1'b1, 1'b0);
        step();
        chk("to execute", {14'd0, state}, 16'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("to wait%0d", i), {14'd0, state}, 16'd2);
        end
        step();
        chk("to state", {14'd0, state}, 16'd0);
        chk("to fault", {15'd0, fault}, 16'd1);
        chk("to halted", {15'd0, halted}, 16'd1);
        chk("to retired", retired, 16'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("to blocked%0d", i), {14'd0, state}, 16'd0);
            chk($sformatf("to sticky%0d", i), {15'd0, fault}, 16'd1);
        end
        reset = 1'b1;
        step();
        chk("to clr fault", {15'd0, fault}, 16'd0);
        chk("to clr halted", {15'd0, halted}, 16'd0);

        // mem_ready on the limit cycle wins over the watchdog.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'hD654, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hD654, 1'b0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 4; i++) step();
        chk("lw execute", {14'd0, state}, 16'd2);
        mem_ready = 1'b1;
        step();
        chk("lw state", {14'd0, state}, 16'd3);
        chk("lw fault", {15'd0, fault}, 16'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hD654, 1'b0, 1'b0, 1'b0);
        step();
        chk("lw retired", retired, 16'd1);

        // Retired counter wrap.
        force dut.retired = 16'hFFFF;
        #1;
        release dut.retired;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("wrap pre", retired, 16'hFFFF);
        step();
        chk("wrap retired", retired, 16'h0000);
        chk("wrap state", {14'd0, state}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 The block SHALL have one parameter: WAIT_LIMIT, default 8'd16, the maximum EXECUTE-state memory wait in cycles (0 = watchdog disabled, range 0-255).
REQ-002 clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 run  in  1  enable for leaving FETCH; does not affect an instruction already in flight.
REQ-005 instruction_in  in  16  ROM instruction word.
REQ-006 instruction_valid  in  1  instruction_in holds a valid word.
REQ-007 instruction_enable  in  1  fetch request from the control decoder.
REQ-008 read_enable  in  1  RAM load pending, from the control decoder.
REQ-009 write_enable  in  1  RAM store pending, from the control decoder.
REQ-010 mem_ready  in  1  RAM load data valid or store accepted.
REQ-011 state  out  2  cycle state: FETCH=00, DECODE=01, EXECUTE=10, STORE=11.
REQ-012 opcode  out  4  instruction register bits [15:12].
REQ-013 x  out  4  instruction register bits [11:8].
REQ-014 y  out  4  instruction register bits [7:4].
REQ-015 z  out  4  instruction register bits [3:0].
REQ-016 retired  out  16  count of completed instructions.
REQ-017 fault  out  1  sticky memory-timeout flag.
REQ-018 halted  out  1  high when state==FETCH and (run==0 or fault==1).

Function
REQ-019 FETCH->DECODE SHALL occur on the edge where run, instruction_enable and instruction_valid are all 1 and fault==0.
- The 16-bit instruction register captures instruction_in on that same edge.
- Otherwise the state holds FETCH and the instruction register is unchanged.
REQ-020 DECODE->EXECUTE SHALL occur unconditionally after one cycle.
REQ-021 EXECUTE with read_enable==0 and write_enable==0 SHALL go to STORE after one cycle.
REQ-022 EXECUTE with read_enable or write_enable high SHALL hold until mem_ready==1 is sampled, then go to STORE on that edge.
REQ-023 STORE->FETCH SHALL occur unconditionally after one cycle, with retired incremented on that edge (modulo 2^16, 16'hFFFF wraps to 16'h0000).
REQ-024 An 8-bit wait counter SHALL clear on entry to EXECUTE and increment each EXECUTE cycle in which an access is pending and mem_ready==0.
REQ-025 When WAIT_LIMIT!=0, the wait counter equals WAIT_LIMIT and mem_ready==0, the next edge SHALL set fault=1 and force state=FETCH.
- retired is not incremented for the aborted instruction.
REQ-026 If mem_ready==1 on the same cycle the limit is reached, mem_ready SHALL win: the block goes to STORE and fault stays 0.
REQ-027 Once set, fault SHALL remain 1 and block all FETCH exits until reset.
REQ-028 run deasserted outside FETCH SHALL NOT stall the current instruction; the block stops at the next FETCH.
REQ-029 instruction_valid and mem_ready SHALL be ignored in states where they are not sampled, per REQ-019 and REQ-022.
REQ-030 Outputs SHALL be registered or decoded only from registers; there is no combinational path from any input to any output.

Reset
REQ-031 On reset==1 at a clock edge, the next state SHALL be:
- state=FETCH
- instruction register=16'h0000 (opcode=x=y=z=0)
- retired=0, fault=0, wait counter=0
- halted equal to !run
REQ-032 Reset SHALL take priority over every transition, including mid-EXECUTE waits and fault.

Verification
REQ-033 Stimulus: run=1, instruction_valid=1, instruction_enable=1, instruction_in=16'h0123 (ADD), no memory access -> required response: states 00,01,10,11,00 on consecutive cycles; opcode=0, x=1, y=2, z=3; retired=1 after 4 cycles.
REQ-034 Stimulus: LOD (16'hC456) with read_enable high in EXECUTE and mem_ready asserted on the 3rd EXECUTE cycle -> required response: EXECUTE lasts exactly 3 cycles, then STORE, then retired increments.
REQ-035 Stimulus: WAIT_LIMIT=4, STR with write_enable high and mem_ready held 0 -> required response: fault=1, state=00 and halted=1 after the timeout; retired unchanged; further valid instructions are not fetched until reset.
REQ-036 Stimulus: same setup as REQ-035 but mem_ready=1 on the limit cycle -> required response: STORE is entered and fault=0.
REQ-037 Stimulus: retired preloaded to 16'hFFFF by running 65535 instructions (or forced), then one more instruction -> required response: retired=16'h0000.
REQ-038 Stimulus: run dropped during DECODE, then reset asserted mid-EXECUTE wait on a second instruction -> required response: the first instruction completes and the block holds FETCH with halted=1; after the reset edge all REQ-031 values are present.
